vend_ctrl: RTL and testbench

Parametrised vending-machine controller; next generation of the team's fixed-price coin FSM. It accumulates credit from a `coin_valid`/`coin_ready` stream of three configurable denominations and issues a vend request on a `vend_valid`/`vend_ready` handshake. Excess credit and cancelled credit are returned greedily as coins over a `chg_valid`/`chg_ready` handshake. It sits between the coin-acceptor front end and the dispenser/change-hopper drivers.

---
 rtl/vend_pkg.sv | 25 ++
 rtl/vend_change_sel.sv | 30 +++
 rtl/vend_ctrl.sv | 146 ++++++++++++++
 tb/tb_vend_ctrl.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// vend_pkg: shared definitions for the vend_ctrl vending-machine controller.
//   state_t      - controller states (IDLE, ACCUM, VEND, CHANGE)
//   COIN_*       - 2-bit coin codes used on the coin and change ports
//   coin_value() - maps a coin code to its value for a given denomination set
package vend_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_VEND   = 2'd2,
        ST_CHANGE = 2'd3
    } state_t;

    localparam logic [1:0] COIN_NONE   = 2'b00;
    localparam logic [1:0] COIN_A_CODE = 2'b01;
    localparam logic [1:0] COIN_B_CODE = 2'b10;
    localparam logic [1:0] COIN_C_CODE = 2'b11;

    function automatic int unsigned coin_value(input logic [1:0] code, input int unsigned a,
                                               input int unsigned b, input int unsigned c);
        return (code == COIN_A_CODE) ? a : (code == COIN_B_CODE) ? b :
               (code == COIN_C_CODE) ? c : 0;
    endfunction

endpackage

// File: rtl/vend_change_sel.sv
// vend_change_sel: greedy change-coin selector (combinational).
//   i_credit    - credit still owed to the customer
//   o_chg_code  - code of the largest denomination not exceeding i_credit
//   o_chg_val   - value of that coin
//   o_none_fits - credit is below the smallest denomination (residue is forfeited)
module vend_change_sel
    import vend_pkg::*;
#(
    parameter int unsigned COIN_A   = 1,
    parameter int unsigned COIN_B   = 2,
    parameter int unsigned COIN_C   = 5,
    parameter int unsigned CREDIT_W = 4
) (
    input  logic [CREDIT_W-1:0] i_credit,
    output logic [1:0]          o_chg_code,
    output logic [CREDIT_W-1:0] o_chg_val,
    output logic                o_none_fits
);

    localparam logic [CREDIT_W-1:0] VAL_A = CREDIT_W'(COIN_A);
    localparam logic [CREDIT_W-1:0] VAL_B = CREDIT_W'(COIN_B);
    localparam logic [CREDIT_W-1:0] VAL_C = CREDIT_W'(COIN_C);

    assign o_chg_code  = (i_credit >= VAL_C) ? COIN_C_CODE :
                         (i_credit >= VAL_B) ? COIN_B_CODE :
                         (i_credit >= VAL_A) ? COIN_A_CODE : COIN_NONE;
    assign o_chg_val   = CREDIT_W'(coin_value(o_chg_code, COIN_A, COIN_B, COIN_C));
    assign o_none_fits = i_credit < VAL_A;

endmodule

// File: rtl/vend_ctrl.sv
// vend_ctrl: parametrised vending-machine controller.
//   Accumulates credit from coins (coin/coin_valid/coin_ready), requests a vend
//   (vend_valid/vend_ready) once credit reaches PRICE, and returns excess or
//   cancelled credit greedily as change coins (chg_valid/chg_code/chg_ready).
//   credit shows the current credit; bad_coin pulses for an accepted code 00.
//   Optional feature macro: VEND_CHANGE_EN enables the CHANGE state and change
//   port; without it residual credit is kept after a vend and cancel forfeits.
module vend_ctrl
    import vend_pkg::*;
#(
    parameter int unsigned PRICE    = 5,
    parameter int unsigned COIN_A   = 1,
    parameter int unsigned COIN_B   = 2,
    parameter int unsigned COIN_C   = 5,
    parameter int unsigned CREDIT_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          coin,
    input  logic                coin_valid,
    output logic                coin_ready,
    input  logic                cancel,
    output logic                vend_valid,
    input  logic                vend_ready,
    output logic                chg_valid,
    output logic [1:0]          chg_code,
    input  logic                chg_ready,
    output logic [CREDIT_W-1:0] credit,
    output logic                bad_coin
);

    if (PRICE < 1) begin : g_chk_price
        $error("vend_ctrl: PRICE must be at least 1");
    end
    if (!(COIN_A < COIN_B && COIN_B < COIN_C)) begin : g_chk_coins
        $error("vend_ctrl: require COIN_A < COIN_B < COIN_C");
    end
    if (PRICE - 1 + COIN_C >= (1 << CREDIT_W)) begin : g_chk_width
        $error("vend_ctrl: CREDIT_W too narrow for PRICE-1+COIN_C");
    end

    localparam logic [1:0]          S_IDLE  = ST_IDLE;
    localparam logic [1:0]          S_ACCUM = ST_ACCUM;
    localparam logic [1:0]          S_VEND  = ST_VEND;
    localparam logic [CREDIT_W-1:0] P       = CREDIT_W'(PRICE);

    logic [1:0]          r_state, w_state_nx;
    logic [CREDIT_W-1:0] r_credit, w_credit_nx, w_coin_val, w_sum, w_after_vend;
    logic                r_bad, w_accept, w_cancel;

    assign coin_ready   = (r_state == S_IDLE) || (r_state == S_ACCUM);
    assign vend_valid   = r_state == S_VEND;
    assign credit       = r_credit;
    assign bad_coin     = r_bad;
    assign w_accept     = coin_valid && coin_ready;
    assign w_cancel     = cancel && (r_state == S_ACCUM);
    assign w_coin_val   = CREDIT_W'(coin_value(coin, COIN_A, COIN_B, COIN_C));
    // Only reached from IDLE/ACCUM where credit < PRICE, so the sum always fits.
    assign w_sum        = r_credit + w_coin_val;
    assign w_after_vend = r_credit - P;

`ifdef VEND_CHANGE_EN
    localparam logic [1:0] S_CHANGE = ST_CHANGE;

    logic [1:0]          w_sel_code;
    logic [CREDIT_W-1:0] w_chg_val;
    logic                w_none_fits;

    vend_change_sel #(
        .COIN_A   (COIN_A),
        .COIN_B   (COIN_B),
        .COIN_C   (COIN_C),
        .CREDIT_W (CREDIT_W)
    ) u_sel (
        .i_credit    (r_credit),
        .o_chg_code  (w_sel_code),
        .o_chg_val   (w_chg_val),
        .o_none_fits (w_none_fits)
    );

    // Credit only moves on a handshake, so the offered coin is stable until taken.
    assign chg_valid = (r_state == S_CHANGE) && !w_none_fits;
    assign chg_code  = chg_valid ? w_sel_code : COIN_NONE;
`else
    logic w_unused;

    assign chg_valid = 1'b0;
    assign chg_code  = COIN_NONE;
    assign w_unused  = chg_ready;
`endif

    always_comb begin
        w_state_nx  = S_IDLE;
        w_credit_nx = '0;
        case (r_state)
            S_IDLE, S_ACCUM: begin
                w_credit_nx = w_accept ? w_sum : r_credit;
                // A coin that completes the price wins over a simultaneous cancel.
                if (w_accept && w_sum >= P)
                    w_state_nx = S_VEND;
                else if (w_cancel) begin
`ifdef VEND_CHANGE_EN
                    w_state_nx = S_CHANGE;
`else
                    w_state_nx  = S_IDLE;
                    w_credit_nx = '0;
`endif
                end
                else
                    w_state_nx = (w_credit_nx != '0) ? S_ACCUM : S_IDLE;
            end
            S_VEND: begin
                w_credit_nx = vend_ready ? w_after_vend : r_credit;
`ifdef VEND_CHANGE_EN
                w_state_nx = !vend_ready ? S_VEND : (w_after_vend != '0) ? S_CHANGE : S_IDLE;
`else
                w_state_nx = !vend_ready ? S_VEND : (w_after_vend >= P) ? S_VEND :
                             (w_after_vend != '0) ? S_ACCUM : S_IDLE;
`endif
            end
`ifdef VEND_CHANGE_EN
            S_CHANGE: begin
                // A residue below the smallest coin is dropped without a beat.
                w_credit_nx = w_none_fits ? '0 : chg_ready ? r_credit - w_chg_val : r_credit;
                w_state_nx  = (w_credit_nx != '0) ? S_CHANGE : S_IDLE;
            end
`endif
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_credit <= '0;
            r_bad    <= 1'b0;
        end
        else begin
            r_state  <= w_state_nx;
            r_credit <= w_credit_nx;
            r_bad    <= w_accept && (coin == COIN_NONE);
        end
    end

endmodule

// File: tb/tb_vend_ctrl.sv
// tb_vend_ctrl: self-checking bench for vend_ctrl with default parameters
// (PRICE 5, coins 1/2/5, CREDIT_W 4); expectations follow VEND_CHANGE_EN.
module tb_vend_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] coin = 2'b00;
    logic       coin_valid = 1'b0;
    logic       cancel = 1'b0;
    logic       vend_ready = 1'b0;
    logic       chg_ready = 1'b0;
    logic       coin_ready, vend_valid, chg_valid, bad_coin;
    logic [1:0] chg_code;
    logic [3:0] credit;

    int checks = 0;
    int errors = 0;

    logic [1:0] chg_q[$];
    logic [3:0] vend_q[$];
    logic [1:0] mon_code;
    logic [3:0] mon_credit;

    vend_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .coin       (coin),
        .coin_valid (coin_valid),
        .coin_ready (coin_ready),
        .cancel     (cancel),
        .vend_valid (vend_valid),
        .vend_ready (vend_ready),
        .chg_valid  (chg_valid),
        .chg_code   (chg_code),
        .chg_ready  (chg_ready),
        .credit     (credit),
        .bad_coin   (bad_coin)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    // Scoreboard: each handshake that will complete on the coming edge is popped here.
    always @(negedge clk) begin
        if (!rst && vend_valid && vend_ready) begin
            checks++;
            if (vend_q.size() == 0) begin
                errors++;
                $display("FAIL vend_unexpected: vend with credit %0d, none expected", credit);
            end
            else begin
                mon_credit = vend_q.pop_front();
                if (credit !== mon_credit) begin
                    errors++;
                    $display("FAIL vend_credit: got %0d expected %0d", credit, mon_credit);
                end
            end
        end
        if (!rst && chg_valid && chg_ready) begin
            checks++;
            if (chg_q.size() == 0) begin
                errors++;
                $display("FAIL chg_unexpected: change code %b, none expected", chg_code);
            end
            else begin
                mon_code = chg_q.pop_front();
                if (chg_code !== mon_code) begin
                    errors++;
                    $display("FAIL chg_code: got %b expected %b", chg_code, mon_code);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic insert(input logic [1:0] c);
        coin = c;
        coin_valid = 1'b1;
        tick();
        coin_valid = 1'b0;
        coin = 2'b00;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) tick();
        checks++;
        if ({coin_ready, vend_valid, chg_valid, chg_code, bad_coin} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 100000", {coin_ready, vend_valid, chg_valid, chg_code, bad_coin});
        end
        checks++;
        if (credit !== 4'd0) begin errors++; $display("FAIL reset_credit: got %0d expected 0", credit); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_coins;
        repeat (4) insert(2'b01);
        checks++;
        if (credit !== 4'd4 || vend_valid !== 1'b0) begin
            errors++;
            $display("FAIL ones_accum: got credit %0d vend %b expected 4 0", credit, vend_valid);
        end
        insert(2'b01);
        checks++;
        if (credit !== 4'd5 || vend_valid !== 1'b1) begin
            errors++;
            $display("FAIL ones_vend: got credit %0d vend %b expected 5 1", credit, vend_valid);
        end
        repeat (3) begin
            tick();
            checks++;
            if (vend_valid !== 1'b1) begin errors++; $display("FAIL vend_hold: got %b expected 1", vend_valid); end
        end
        vend_q.push_back(4'd5);
        vend_ready = 1'b1;
        tick();
        vend_ready = 1'b0;
        checks++;
        if (credit !== 4'd0 || coin_ready !== 1'b1 || vend_valid !== 1'b0 || vend_q.size() != 0) begin
            errors++;
            $display("FAIL ones_done: got credit %0d ready %b vend %b pending %0d expected 0 1 0 0",
                     credit, coin_ready, vend_valid, vend_q.size());
        end
    endtask

    task automatic test_change_after_vend;
        insert(2'b10);
        insert(2'b10);
        insert(2'b11);
        checks++;
        if (credit !== 4'd9 || vend_valid !== 1'b1) begin
            errors++;
            $display("FAIL c9_vend: got credit %0d vend %b expected 9 1", credit, vend_valid);
        end
        vend_q.push_back(4'd9);
`ifdef VEND_CHANGE_EN
        chg_q.push_back(2'b10);
        chg_q.push_back(2'b10);
`endif
        vend_ready = 1'b1;
        tick();
        vend_ready = 1'b0;
        checks++;
        if (credit !== 4'd4) begin errors++; $display("FAIL c9_residue: got %0d expected 4", credit); end
`ifdef VEND_CHANGE_EN
        checks++;
        if (chg_valid !== 1'b1) begin errors++; $display("FAIL c9_chg_latency: got %b expected 1", chg_valid); end
        tick();
        checks++;
        if (credit !== 4'd2 || chg_valid !== 1'b1) begin
            errors++;
            $display("FAIL c9_chg_beat: got credit %0d valid %b expected 2 1", credit, chg_valid);
        end
        tick();
        checks++;
        if (credit !== 4'd0 || coin_ready !== 1'b1 || chg_q.size() != 0) begin
            errors++;
            $display("FAIL c9_chg_done: got credit %0d ready %b pending %0d expected 0 1 0",
                     credit, coin_ready, chg_q.size());
        end
`else
        checks++;
        if (coin_ready !== 1'b1 || vend_valid !== 1'b0 || chg_valid !== 1'b0) begin
            errors++;
            $display("FAIL c9_accum: got ready %b vend %b chg %b expected 1 0 0", coin_ready, vend_valid, chg_valid);
        end
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        checks++;
        if (credit !== 4'd0) begin errors++; $display("FAIL c9_clear: got %0d expected 0", credit); end
`endif
    endtask

    task automatic test_cancel;
        insert(2'b01);
        insert(2'b10);
`ifdef VEND_CHANGE_EN
        chg_q.push_back(2'b10);
        chg_q.push_back(2'b01);
`endif
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
`ifdef VEND_CHANGE_EN
        checks++;
        if (chg_valid !== 1'b1 || credit !== 4'd3) begin
            errors++;
            $display("FAIL cancel_start: got valid %b credit %0d expected 1 3", chg_valid, credit);
        end
        for (int i = 0; i < 8 && !coin_ready; i++) tick();
        checks++;
        if (credit !== 4'd0 || coin_ready !== 1'b1 || chg_q.size() != 0) begin
            errors++;
            $display("FAIL cancel_done: got credit %0d ready %b pending %0d expected 0 1 0",
                     credit, coin_ready, chg_q.size());
        end
`else
        checks++;
        if (credit !== 4'd0 || chg_valid !== 1'b0 || coin_ready !== 1'b1) begin
            errors++;
            $display("FAIL cancel_forfeit: got credit %0d chg %b ready %b expected 0 0 1", credit, chg_valid, coin_ready);
        end
`endif
    endtask

    task automatic test_bad_coin;
        insert(2'b01);
        insert(2'b00);
        checks++;
        if (bad_coin !== 1'b1 || credit !== 4'd1) begin
            errors++;
            $display("FAIL bad_pulse: got bad %b credit %0d expected 1 1", bad_coin, credit);
        end
        tick();
        checks++;
        if (bad_coin !== 1'b0) begin errors++; $display("FAIL bad_clear: got %b expected 0", bad_coin); end
        insert(2'b11);
        coin = 2'b01;
        coin_valid = 1'b1;
        checks++;
        if (coin_ready !== 1'b0) begin errors++; $display("FAIL vend_coin_ready: got %b expected 0", coin_ready); end
        tick();
        checks++;
        if (credit !== 4'd6 || vend_valid !== 1'b1) begin
            errors++;
            $display("FAIL vend_coin_block: got credit %0d vend %b expected 6 1", credit, vend_valid);
        end
        coin_valid = 1'b0;
        coin = 2'b00;
        vend_q.push_back(4'd6);
`ifdef VEND_CHANGE_EN
        chg_q.push_back(2'b01);
`endif
        vend_ready = 1'b1;
        tick();
        vend_ready = 1'b0;
`ifdef VEND_CHANGE_EN
        tick();
        checks++;
        if (credit !== 4'd0 || coin_ready !== 1'b1 || chg_q.size() != 0) begin
            errors++;
            $display("FAIL bad_seq_done: got credit %0d ready %b pending %0d expected 0 1 0",
                     credit, coin_ready, chg_q.size());
        end
`else
        checks++;
        if (credit !== 4'd1 || coin_ready !== 1'b1) begin
            errors++;
            $display("FAIL bad_seq_keep: got credit %0d ready %b expected 1 1", credit, coin_ready);
        end
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
`endif
    endtask

    task automatic test_coin_cancel;
        insert(2'b10);
        insert(2'b10);
        coin = 2'b01;
        coin_valid = 1'b1;
        cancel = 1'b1;
        tick();
        coin_valid = 1'b0;
        cancel = 1'b0;
        checks++;
        if (vend_valid !== 1'b1 || credit !== 4'd5 || chg_valid !== 1'b0) begin
            errors++;
            $display("FAIL cc_vend: got vend %b credit %0d chg %b expected 1 5 0", vend_valid, credit, chg_valid);
        end
        vend_q.push_back(4'd5);
        vend_ready = 1'b1;
        tick();
        vend_ready = 1'b0;
        checks++;
        if (credit !== 4'd0 || coin_ready !== 1'b1) begin
            errors++;
            $display("FAIL cc_vend_done: got credit %0d ready %b expected 0 1", credit, coin_ready);
        end
        insert(2'b01);
`ifdef VEND_CHANGE_EN
        chg_q.push_back(2'b10);
`endif
        coin = 2'b01;
        coin_valid = 1'b1;
        cancel = 1'b1;
        tick();
        coin_valid = 1'b0;
        cancel = 1'b0;
`ifdef VEND_CHANGE_EN
        checks++;
        if (chg_valid !== 1'b1 || chg_code !== 2'b10 || credit !== 4'd2) begin
            errors++;
            $display("FAIL cc_change: got valid %b code %b credit %0d expected 1 10 2", chg_valid, chg_code, credit);
        end
        tick();
        checks++;
        if (credit !== 4'd0 || coin_ready !== 1'b1 || chg_q.size() != 0) begin
            errors++;
            $display("FAIL cc_change_done: got credit %0d ready %b pending %0d expected 0 1 0",
                     credit, coin_ready, chg_q.size());
        end
`else
        checks++;
        if (credit !== 4'd0 || coin_ready !== 1'b1 || chg_valid !== 1'b0) begin
            errors++;
            $display("FAIL cc_forfeit: got credit %0d ready %b chg %b expected 0 1 0", credit, coin_ready, chg_valid);
        end
`endif
    endtask

    task automatic test_reset_midway;
        insert(2'b11);
        checks++;
        if (vend_valid !== 1'b1) begin errors++; $display("FAIL mid_vend_setup: got %b expected 1", vend_valid); end
        rst = 1'b1;
        tick();
        checks++;
        if ({coin_ready, vend_valid, chg_valid, chg_code, bad_coin} !== 6'b100000 || credit !== 4'd0) begin
            errors++;
            $display("FAIL mid_vend_reset: got flags %b credit %0d expected 100000 0",
                     {coin_ready, vend_valid, chg_valid, chg_code, bad_coin}, credit);
        end
        rst = 1'b0;
        tick();
`ifdef VEND_CHANGE_EN
        chg_ready = 1'b0;
        insert(2'b01);
        insert(2'b10);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        checks++;
        if (chg_valid !== 1'b1) begin errors++; $display("FAIL mid_chg_setup: got %b expected 1", chg_valid); end
        rst = 1'b1;
        tick();
        checks++;
        if ({coin_ready, vend_valid, chg_valid, chg_code, bad_coin} !== 6'b100000 || credit !== 4'd0) begin
            errors++;
            $display("FAIL mid_chg_reset: got flags %b credit %0d expected 100000 0",
                     {coin_ready, vend_valid, chg_valid, chg_code, bad_coin}, credit);
        end
        rst = 1'b0;
        tick();
        chg_ready = 1'b1;
`endif
    endtask

    initial begin
        test_reset();
`ifdef VEND_CHANGE_EN
        chg_ready = 1'b1;
`endif
        test_single_coins();
        test_change_after_vend();
        test_cancel();
        test_bad_coin();
        test_coin_cancel();
        test_reset_midway();
        repeat (2) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
